fp_result_queue: RTL
====================

// Module: fp_result_queue
// PURPOSE
//   Output buffer that sits directly downstream of fp_reciprocal_pipeline. That pipeline cannot stall.
//   This block captures every {result, exception flags} it produces into a FIFO with ready/valid drain.
//   It tracks in-flight operations so the issuing logic only starts a reciprocal when a slot is guaranteed.
//   It also accumulates IEEE-754 exception flags into a sticky status register (FPSCR-style) until cleared.
// PARAMETERS
//   DEPTH         8   FIFO entries (>=2, need not be a power of 2)
//   MAX_INFLIGHT  16  capacity of the in-flight counter (>= pipeline latency)
// PORTS
//   clk             in   1   clock; all state updates on posedge
//   rst             in   1   synchronous, active-high reset
//   issue_valid     in   1   high on the cycle the issuer drives valid_data_in=1 into the pipeline
//   issue_ok        out  1   issuer may start an operation this cycle
//   res_valid       in   1   pipeline valid_data_out
//   res_data        in   32  pipeline out (binary32)
//   res_flags       in   5   {overflow, underflow, inexact, invalid_operation, division_by_zero}
//   out_valid       out  1   head entry available (first-word fall-through)
//   out_ready       in   1   consumer accepts head when out_valid&&out_ready
//   out_data        out  32  head result
//   out_flags       out  5   head flags, same order as res_flags
//   count           out  $clog2(DEPTH+1)  current occupancy
//   sticky_flags    out  5   OR of flags of all accepted results since last clear/reset
//   clear_flags     in   1   one-cycle pulse clears sticky_flags
//   overrun_error   out  1   sticky; set on dropped result or unmatched res_valid
// BEHAVIOUR
//   Reset (rst=1 at posedge) sets the following to 0:
//     rd_ptr, wr_ptr, count, inflight, sticky_flags, overrun_error.
//     Consequently out_valid=0 and issue_ok=1. FIFO storage is not cleared.
//     A reset mid-operation discards all queued and in-flight results.
//   issue_ok = (count + inflight) < DEPTH, using only registered values (no input-to-output path).
//   inflight counter (0..MAX_INFLIGHT):
//     +1 on issue_valid alone; -1 on res_valid alone; unchanged when both are high.
//     res_valid with inflight==0 and no issue_valid: counter holds at 0 and overrun_error is set.
//     issue_valid with inflight==MAX_INFLIGHT: counter saturates and overrun_error is set.
//     issue_valid while issue_ok=0 is still counted; it is not blocked.
//   pop = out_valid && out_ready; push = res_valid && (count<DEPTH || pop).
//     push writes {res_data,res_flags} at wr_ptr.
//     Pointers advance by 1 and wrap DEPTH-1 -> 0.
//     count +1 on push only, -1 on pop only, unchanged on both.
//   Full (count==DEPTH) with simultaneous pop and res_valid: push is accepted; count stays DEPTH.
//   Full with res_valid and no pop: result is dropped, pointers unchanged, overrun_error set.
//   Empty with res_valid: no bypass. The entry is written and out_valid rises the next cycle (latency 1).
//   out_valid = (count!=0). out_data/out_flags are read combinationally from mem[rd_ptr].
//     They are held stable while out_valid && !out_ready.
//   sticky_flags:
//     sticky <= clear_flags ? (push ? res_flags : 0) : sticky | (push ? res_flags : 0).
//     Clear and push in the same cycle: the new entry's flags survive.
//     Dropped results do not update sticky_flags.
//   overrun_error is cleared only by rst.
// TESTING
//   1) After reset, res_valid with 0x3F800000 and flags 0: out_valid=1 next cycle, out_data=0x3F800000, count=1.
//   2) res_data 0x7F800000 with division_by_zero=1 (recip of +0), then 0x3F000000 with inexact=0:
//      sticky_flags=5'b00001. clear_flags pulsed together with a push carrying inexact: sticky=5'b00100.
//   3) out_ready=0, push DEPTH=8 results: count=8, issue_ok=0.
//      9th res_valid is dropped and overrun_error=1. Popping then returns results 1..8 in order.
//   4) Full queue, res_valid and out_ready high in the same cycle: count stays 8,
//      the head advances, and the new entry lands last with no overrun.
//   5) 3 issue_valid pulses with count=5: issue_ok falls after the 3rd.
//      res_valid+issue_valid in one cycle leaves inflight unchanged. res_valid with inflight=0 sets overrun_error.
//   6) Wrap check: 20 push/pop pairs at DEPTH=8 return data in order.
//      Assert rst mid-stream: out_valid=0, count=0, issue_ok=1 on the next cycle.

Source files
------------

// File: rtl/fp_result_queue.sv
// ---------------------------------------------------------------------------
// fp_result_queue
//
// Output buffer for a reciprocal pipeline that cannot stall. Every result the
// pipeline produces ({binary32 result, 5 exception flags}) is captured into a
// FIFO. The FIFO is drained through a ready/valid port with first-word
// fall-through.
//
// The block also counts operations that are in flight inside the pipeline.
// issue_ok is raised only when a FIFO slot is guaranteed for every queued and
// in-flight result. Exception flags of accepted results are ORed into a sticky
// status register until it is cleared.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   issue_valid    issuer starts an operation this cycle (always counted)
//   issue_ok       issuer may start an operation (registered state only)
//   res_valid      pipeline result strobe
//   res_data       pipeline result (binary32)
//   res_flags      {overflow, underflow, inexact, invalid, div_by_zero}
//   out_valid      head entry available
//   out_ready      consumer accepts head
//   out_data       head result
//   out_flags      head flags
//   count          FIFO occupancy
//   sticky_flags   OR of flags of all accepted results since clear/reset
//   clear_flags    one-cycle pulse clears sticky_flags
//   overrun_error  sticky error: dropped result or inflight under/overflow
//
// Handshake: the head entry transfers on any rising clk edge where
// out_valid && out_ready are both high. out_valid does not depend on
// out_ready. While out_valid is high and out_ready is low, out_data and
// out_flags hold their values. There is no backpressure toward the pipeline.
// A result that arrives when the FIFO is full and no pop happens that cycle
// is dropped and flagged.
// ---------------------------------------------------------------------------
module fp_result_queue #(
    parameter int DEPTH        = 8,
    parameter int MAX_INFLIGHT = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         issue_valid,
    output logic                         issue_ok,
    input  logic                         res_valid,
    input  logic [31:0]                  res_data,
    input  logic [4:0]                   res_flags,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_data,
    output logic [4:0]                   out_flags,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [4:0]                   sticky_flags,
    input  logic                         clear_flags,
    output logic                         overrun_error
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int IW = $clog2(MAX_INFLIGHT + 1);
    // The sum width covers both counters plus a carry bit.
    localparam int SW = ((IW > CW) ? IW : CW) + 1;
    localparam int EW = 37;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;
    logic [IW-1:0] inflight_q;
    logic [4:0]    sticky_q;
    logic          overrun_q;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    logic          pop, push, drop;
    logic          full;
    logic [PW-1:0] rd_ptr_d, wr_ptr_d;
    logic [CW-1:0] count_d;
    logic [IW-1:0] inflight_d;
    logic          inflight_err;
    logic [4:0]    new_flags;
    logic [4:0]    sticky_d;
    logic [SW-1:0] committed;

    always_comb begin
        full = (count_q == CW'(DEPTH));
        pop  = out_valid && out_ready;
        // A full FIFO can still accept a push when the head leaves this cycle.
        push = res_valid && (!full || pop);
        drop = res_valid && !push;
    end

    // Pointer advance with wrap at DEPTH-1. DEPTH need not be a power of two.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // In-flight tracking. A simultaneous issue and result cancel out.
    // Underflow (result with nothing in flight) and overflow (issue at
    // capacity) both hold the counter and raise the error.
    always_comb begin
        inflight_d   = inflight_q;
        inflight_err = 1'b0;
        unique case ({issue_valid, res_valid})
            2'b10: begin
                if (inflight_q == IW'(MAX_INFLIGHT)) begin
                    inflight_err = 1'b1;
                end else begin
                    inflight_d = inflight_q + IW'(1);
                end
            end
            2'b01: begin
                if (inflight_q == '0) begin
                    inflight_err = 1'b1;
                end else begin
                    inflight_d = inflight_q - IW'(1);
                end
            end
            default: inflight_d = inflight_q;
        endcase
    end

    // Sticky flags: a clear in the same cycle as a push keeps the flags of
    // the new entry. A dropped result never contributes.
    always_comb begin
        new_flags = push ? res_flags : 5'b0;
        sticky_d  = clear_flags ? new_flags : (sticky_q | new_flags);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            sticky_q   <= '0;
            overrun_q  <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            sticky_q   <= sticky_d;
            if (drop || inflight_err) begin
                overrun_q <= 1'b1;
            end
        end
    end

    // Storage is left uninitialised by reset. Only the occupancy decides
    // whether an entry is meaningful.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr_q] <= {res_data, res_flags};
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        // Registered values only, so there is no combinational path from
        // issue_valid or res_valid to issue_ok.
        committed = SW'(count_q) + SW'(inflight_q);
        issue_ok  = (committed < SW'(DEPTH));
    end

    assign out_valid     = (count_q != '0);
    assign out_data      = mem[rd_ptr_q][EW-1:5];
    assign out_flags     = mem[rd_ptr_q][4:0];
    assign count         = count_q;
    assign sticky_flags  = sticky_q;
    assign overrun_error = overrun_q;

endmodule
